// File: rtl/param_ring_counter.sv
// -----------------------------------------------------------------------------
// param_ring_counter
//
// Parametrised ring / Johnson counter used as a one-hot sequencer or phase
// generator. It steps up or down under an enable, can be parallel-loaded, and
// reports a registered sequence position plus a one-cycle wrap pulse.
//
// Parameters
//   WIDTH  number of state bits (>= 2)
//   MODE   0 = ring (WIDTH one-hot states), 1 = Johnson (2*WIDTH states)
//   IDXW   width of idx_o
//
// Ports
//   clk_i       clock, rising edge
//   rst_ni      asynchronous reset, active low
//   en_i        step enable
//   dir_i       0 = up (toward MSB), 1 = down (toward LSB)
//   load_i      synchronous parallel load, wins over en_i
//   load_val_i  value captured on load
//   dout_o      counter state
//   idx_o       position of dout_o in the sequence, 0 = home
//   wrap_o      one-cycle pulse when a step crosses the sequence end
//   err_o       one-cycle illegal-state flag (0 unless self-correction built)
//
// Build option
//   RING_SELF_CORRECT_EN  when defined, illegal load values are rejected and
//                         an illegal state is forced back to home, each with
//                         a one-cycle err_o pulse. When undefined, err_o is 0
//                         and any value circulates as loaded.
// -----------------------------------------------------------------------------
module param_ring_counter #(
    parameter int WIDTH = 4,
    parameter int MODE  = 0,
    parameter int IDXW  = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [IDXW-1:0]  idx_o,
    output logic             wrap_o,
    output logic             err_o
);

    localparam int               NSTATES  = (MODE == 0) ? WIDTH : 2 * WIDTH;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NSTATES - 1);
    localparam logic [WIDTH-1:0] HOME     = (MODE == 0) ? WIDTH'(1) : '0;

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [IDXW-1:0]  idx_q,  idx_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] step_dout;
    logic [IDXW-1:0]  step_idx;
    logic             step_wrap;

    // Sequence position of an arbitrary value. Ring: lowest set bit.
    // Johnson: the rising half (bit 0 set, or all zeros) counts ones; the
    // falling half sits WIDTH past the all-ones state, offset by its zeros.
    function automatic logic [IDXW-1:0] decode_idx(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] r;
        logic [IDXW-1:0] ones;
        logic [IDXW-1:0] zeros;
        r     = '0;
        ones  = '0;
        zeros = '0;
        if (MODE == 0) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) r = IDXW'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) ones  = ones + IDXW'(1);
                else      zeros = zeros + IDXW'(1);
            end
            if (v[0] || (v == '0)) r = ones;
            else                   r = IDXW'(WIDTH) + zeros;
        end
        return r;
    endfunction

`ifdef RING_SELF_CORRECT_EN
    logic err_q, err_d;

    // Ring: exactly one bit set. Johnson: a low-side thermometer (v+1 has no
    // overlap with v) or its complement, which together cover all 2*WIDTH
    // states including zero and all-ones.
    function automatic logic is_legal(input logic [WIDTH-1:0] v);
        logic ok;
        if (MODE == 0) begin
            ok = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
        end else begin
            ok = ((v & (v + WIDTH'(1))) == '0) ||
                 ((~v & (~v + WIDTH'(1))) == '0);
        end
        return ok;
    endfunction
`endif

    // One step of the sequence in the current direction, with wrap detection
    always_comb begin
        step_dout = dout_q;
        step_idx  = idx_q;
        step_wrap = 1'b0;
        if (!dir_i) begin
            step_dout = {dout_q[WIDTH-2:0],
                         (MODE == 0) ? dout_q[WIDTH-1] : ~dout_q[WIDTH-1]};
            if (idx_q == LAST_IDX) begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end else begin
                step_idx  = idx_q + IDXW'(1);
            end
        end else begin
            step_dout = {(MODE == 0) ? dout_q[0] : ~dout_q[0],
                         dout_q[WIDTH-1:1]};
            if (idx_q == '0) begin
                step_idx  = LAST_IDX;
                step_wrap = 1'b1;
            end else begin
                step_idx  = idx_q - IDXW'(1);
            end
        end
    end

    // Next-state selection: load, then (optionally) correction, then step
    always_comb begin
        dout_d = dout_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
`ifdef RING_SELF_CORRECT_EN
        err_d  = 1'b0;
        if (load_i && is_legal(load_val_i)) begin
            dout_d = load_val_i;
            idx_d  = decode_idx(load_val_i);
        end else if (!is_legal(dout_q)) begin
            dout_d = HOME;
            idx_d  = '0;
            err_d  = 1'b1;
        end else if (load_i) begin
            // illegal load value: hold state and flag it
            err_d  = 1'b1;
        end else if (en_i) begin
            dout_d = step_dout;
            idx_d  = step_idx;
            wrap_d = step_wrap;
        end
`else
        if (load_i) begin
            dout_d = load_val_i;
            idx_d  = decode_idx(load_val_i);
        end else if (en_i) begin
            dout_d = step_dout;
            idx_d  = step_idx;
            wrap_d = step_wrap;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_q <= HOME;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef RING_SELF_CORRECT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign dout_o = dout_q;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_param_ring_counter.sv
// -----------------------------------------------------------------------------
// tb_param_ring_counter
//
// Directed bench driving a ring instance (WIDTH=4, MODE=0) and a Johnson
// instance (WIDTH=4, MODE=1) from shared controls, with separate load values.
// Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_param_ring_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] r_load_val;
    logic [3:0] j_load_val;

    logic [3:0] r_dout, j_dout;
    logic [2:0] r_idx,  j_idx;
    logic       r_wrap, j_wrap;
    logic       r_err,  j_err;

    int err_cnt = 0;
    int chk_cnt = 0;

    param_ring_counter #(.WIDTH(4), .MODE(0)) u_ring (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (r_load_val),
        .dout_o     (r_dout),
        .idx_o      (r_idx),
        .wrap_o     (r_wrap),
        .err_o      (r_err)
    );

    param_ring_counter #(.WIDTH(4), .MODE(1)) u_john (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (j_load_val),
        .dout_o     (j_dout),
        .idx_o      (j_idx),
        .wrap_o     (j_wrap),
        .err_o      (j_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] rd, input logic [2:0] ri,
                           input logic rw, input logic re,
                           input logic [3:0] jd, input logic [2:0] ji,
                           input logic jw, input logic je);
        check_val({tag, ".r_dout"}, 32'(r_dout), 32'(rd));
        check_val({tag, ".r_idx"},  32'(r_idx),  32'(ri));
        check_val({tag, ".r_wrap"}, 32'(r_wrap), 32'(rw));
        check_val({tag, ".r_err"},  32'(r_err),  32'(re));
        check_val({tag, ".j_dout"}, 32'(j_dout), 32'(jd));
        check_val({tag, ".j_idx"},  32'(j_idx),  32'(ji));
        check_val({tag, ".j_wrap"}, 32'(j_wrap), 32'(jw));
        check_val({tag, ".j_err"},  32'(j_err),  32'(je));
    endtask

    // advance one clock; inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [3:0] r_up_d [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                               4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] r_up_i [8] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic       r_up_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] j_up_d [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                               4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] j_up_i [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       j_up_w [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        dir        = 1'b0;
        load       = 1'b0;
        r_load_val = 4'b0000;
        j_load_val = 4'b0000;
        repeat (2) @(negedge clk);
        chk_all("reset", 4'b0001, 3'd0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);

        // release and count up through two ring laps / one Johnson lap
        rst_n = 1'b1;
        en    = 1'b1;
        dir   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all($sformatf("up%0d", i), r_up_d[i], r_up_i[i], r_up_w[i], 1'b0,
                    j_up_d[i], j_up_i[i], j_up_w[i], 1'b0);
        end

        // down from home wraps to the last state
        dir = 1'b1;
        tick();
        chk_all("down0", 4'b1000, 3'd3, 1'b1, 1'b0, 4'b1000, 3'd7, 1'b1, 1'b0);
        tick();
        chk_all("down1", 4'b0100, 3'd2, 1'b0, 1'b0, 4'b1100, 3'd6, 1'b0, 1'b0);

        // hold
        en = 1'b0;
        tick();
        chk_all("hold", 4'b0100, 3'd2, 1'b0, 1'b0, 4'b1100, 3'd6, 1'b0, 1'b0);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 4'b0001, 3'd0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_all("post_rst", 4'b0001, 3'd0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0);

        // load has priority over enable
        en         = 1'b1;
        dir        = 1'b0;
        load       = 1'b1;
        r_load_val = 4'b0100;
        j_load_val = 4'b1100;
        tick();
        chk_all("load0", 4'b0100, 3'd2, 1'b0, 1'b0, 4'b1100, 3'd6, 1'b0, 1'b0);
        r_load_val = 4'b1000;
        j_load_val = 4'b0111;
        tick();
        chk_all("load1", 4'b1000, 3'd3, 1'b0, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0);

        // illegal load values
        en         = 1'b0;
        r_load_val = 4'b0110;
        j_load_val = 4'b0101;
        tick();
`ifdef RING_SELF_CORRECT_EN
        chk_all("bad_load", 4'b1000, 3'd3, 1'b0, 1'b1, 4'b0111, 3'd3, 1'b0, 1'b1);
`else
        chk_all("bad_load", 4'b0110, 3'd1, 1'b0, 1'b0, 4'b0101, 3'd2, 1'b0, 1'b0);
`endif
        load = 1'b0;
        tick();
`ifdef RING_SELF_CORRECT_EN
        chk_all("bad_hold", 4'b1000, 3'd3, 1'b0, 1'b0, 4'b0111, 3'd3, 1'b0, 1'b0);
`else
        chk_all("bad_hold", 4'b0110, 3'd1, 1'b0, 1'b0, 4'b0101, 3'd2, 1'b0, 1'b0);
`endif

        // step after the illegal load attempt
        en = 1'b1;
        tick();
`ifdef RING_SELF_CORRECT_EN
        chk_all("bad_step", 4'b0001, 3'd0, 1'b1, 1'b0, 4'b1111, 3'd4, 1'b0, 1'b0);
`else
        chk_all("bad_step", 4'b1100, 3'd2, 1'b0, 1'b0, 4'b1011, 3'd3, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/param_ring_counter.md
# param_ring_counter

Parametrised ring/Johnson counter, the successor to the fixed 4-bit ring counter. It provides configurable width, a ring (one-hot) or Johnson (twisted-ring) mode, up/down rotation, enable, synchronous parallel load, a registered position index and a wrap pulse. It serves as a one-hot sequencer or phase generator for downstream control logic.

## Interface
- WIDTH, 4: number of state bits; must be ≥ 2.
- MODE, 0: 0 = ring (WIDTH states, one-hot); 1 = Johnson (2·WIDTH states, thermometer).
- IDXW, $clog2(2*WIDTH): width of idx.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  step enable.
- dir  in  1  0 = up (shift toward MSB); 1 = down (shift toward LSB).
- load  in  1  synchronous parallel load; has priority over en.
- load_val  in  WIDTH  value captured when load = 1.
- dout  out  WIDTH  counter state.
- idx  out  IDXW  position of dout in the sequence, 0 = home.
- wrap  out  1  one-cycle pulse on a sequence wrap.
- err  out  1  one-cycle illegal-state flag (see Configuration).

## Operation
- Home state:
  - MODE 0: dout = 1 (bit 0 set).
  - MODE 1: dout = 0.
  - idx = 0 at home.
- Ring mode:
  - Up: dout ← {dout[W-2:0], dout[W-1]}; idx ← (idx+1) mod WIDTH.
  - Down: dout ← {dout[0], dout[W-1:1]}; idx ← (idx−1) mod WIDTH.
- Johnson mode:
  - Up: dout ← {dout[W-2:0], ~dout[W-1]}; idx ← (idx+1) mod 2·WIDTH.
  - Down: dout ← {~dout[0], dout[W-1:1]}; idx ← (idx−1) mod 2·WIDTH.
- Cycle priority: rst, then load, then en, then hold.
- en = 0 and load = 0: all state holds; wrap = 0 and err = 0.
- Load: dout ← load_val, and idx is decoded from load_val:
  - Ring: idx = index of the lowest set bit.
  - Johnson, load_val[0] = 1 or load_val = 0: idx = popcount(load_val).
  - Johnson, otherwise: idx = WIDTH + number of zeros in load_val.
- wrap asserts only after a step (not after a load):
  - Up: idx crossed last → 0.
  - Down: idx crossed 0 → last.
- dir may change on any cycle and applies to the next step; there is no pipeline effect.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: 2^k−1 or ~(2^k−1), for 0 ≤ k < WIDTH, plus all-ones.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Step latency: an en = 1 sampled at edge N is visible on dout/idx after edge N.
- wrap is high in the same cycle that dout shows the post-wrap state.
- load: load_val is visible on dout after the sampling edge.
- Reset values, applied immediately on rst falling (no clock needed): dout = home, idx = 0, wrap = 0, err = 0.
- Reset release: the first step occurs at the first rising edge with rst = 1 and en = 1.

## Configuration
- Macro: RING_SELF_CORRECT_EN.
- With the macro defined:
  - A load with illegal load_val is rejected: dout and idx hold, and err pulses for 1 cycle.
  - An illegal dout at any edge is forced to home with idx = 0 and err pulsed for 1 cycle. This takes priority over en; a legal load takes priority over the correction.
- Without the macro:
  - No checking; err is tied to 0.
  - Illegal load_val is loaded verbatim and idx uses the decode rules above.
  - Illegal states circulate indefinitely.

## Test plan
- Ring up, WIDTH=4, MODE=0: hold rst low, then release with en=1, dir=0 → dout 0001 → 0010 → 0100 → 1000 → 0001; idx 0,1,2,3,0; wrap=1 only in the cycle showing 0001, idx=0.
- Ring down: from 0001, dir=1, en=1 → dout 1000, idx 3, wrap=1; next cycle 0100, wrap=0.
- Johnson up, MODE=1, WIDTH=4: 0000 → 0001 → 0011 → 0111 → 1111 → 1110 → 1100 → 1000 → 0000; idx 0..7 then 0; wrap=1 at the returning 0000.
- Load over enable: load=1, en=1, load_val=0100 (MODE 0) → dout 0100, idx 2, wrap 0; MODE 1 load_val=1100 → idx 6.
- Illegal load, MODE 0, load_val=0110:
  - Macro defined: dout holds, err=1 for exactly one cycle.
  - Macro undefined: dout=0110, idx=1, err=0.
- Asynchronous reset mid-count: drive rst low between edges while dout=0100 → dout=0001, idx=0, wrap=0 immediately, before the next clk edge.
